// File: rtl/nascom_vram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// nascom_vram_arbiter_pkg
//   Shared types and constants for the NASCOM video RAM arbiter.
//   - state_t            : CPU access FSM encoding (IDLE/CPU_RD/CPU_WR/HOLD)
//   - NASCOM_VRAM_BLANK  : character code of a blank (space) cell
//   - SLOT_W             : width of the character-slot counter (CHAR_CLKS <= 16)
//   - slot_next()        : wrapping increment used by the slot counter
// ---------------------------------------------------------------------------
package nascom_vram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CPU_RD = 2'd1,
    ST_CPU_WR = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [7:0] NASCOM_VRAM_BLANK = 8'h20;
  localparam int         SLOT_W            = 4;

  // Next value of a counter that runs 0..last and wraps back to 0.
  function automatic logic [SLOT_W-1:0] slot_next(input logic [SLOT_W-1:0] cur,
                                                  input logic [SLOT_W-1:0] last);
    logic [SLOT_W-1:0] nxt;
    if (cur == last) begin
      nxt = {SLOT_W{1'b0}};
    end else begin
      nxt = cur + {{(SLOT_W-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

endpackage

// File: rtl/nascom_vram_arbiter_slot_ctr.sv
// ---------------------------------------------------------------------------
// nascom_vram_arbiter_slot_ctr
//   Free-running character-slot counter. Counts 0..CHAR_CLKS-1 every clock
//   and never stalls; slot 0 is the display fetch slot.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset (counter -> 0)
//     o_slot_cnt   current slot number
//     o_slot0      high while the counter is in slot 0
// ---------------------------------------------------------------------------
module nascom_vram_arbiter_slot_ctr
  import nascom_vram_arbiter_pkg::*;
#(
  parameter int CHAR_CLKS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [SLOT_W-1:0] o_slot_cnt,
  output logic              o_slot0
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHAR_CLKS - 1);

  logic [SLOT_W-1:0] r_slot_cnt;

  // Slot counter register, wraps at the last slot of the character period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_cnt <= {SLOT_W{1'b0}};
    end else begin
      r_slot_cnt <= slot_next(r_slot_cnt, LAST_SLOT);
    end
  end

  assign o_slot_cnt = r_slot_cnt;
  assign o_slot0    = (r_slot_cnt == {SLOT_W{1'b0}});

endmodule

// File: rtl/nascom_vram_arbiter.sv
// ---------------------------------------------------------------------------
// nascom_vram_arbiter
//   Shares the single-port NASCOM video RAM between Z80 accesses and the CRT
//   character fetch. Slot 0 of each character period belongs to the display
//   fetch; every other cycle serves the CPU. The RAM address/control outputs
//   are registered; the RAM is expected to deliver the data for the address
//   registered at edge N so that it can be sampled at edge N+1.
//
//   Optional feature macro: NASCOM_VRAM_WAIT_EN
//     defined   : display wins slot 0, CPU is held off with WAIT for one clock
//     undefined : CPU always wins ("snow"), WAIT tied inactive
//
//   Ports:
//     clk, rst_n                   clock, asynchronous active-low reset
//     i_cpu_req/i_cpu_wr           CPU access request (level) and direction
//     i_cpu_addr/i_cpu_wdata       CPU address and write data
//     o_cpu_rdata/o_cpu_ack        read data and one-cycle completion pulse
//     o_cpu_wait_n                 active-low Z80 WAIT
//     i_disp_active/i_disp_addr    display fetch enable and character address
//     o_disp_data/o_disp_valid     fetched character and update pulse
//     o_ram_addr/o_ram_we/
//     o_ram_wdata/i_ram_rdata      video RAM port
//     o_coll_cnt                   saturating CPU/display collision count
// ---------------------------------------------------------------------------
module nascom_vram_arbiter
  import nascom_vram_arbiter_pkg::*;
#(
  parameter int CHAR_CLKS = 8,
  parameter int AW        = 10,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cpu_req,
  input  logic             i_cpu_wr,
  input  logic [AW-1:0]    i_cpu_addr,
  input  logic [7:0]       i_cpu_wdata,
  output logic [7:0]       o_cpu_rdata,
  output logic             o_cpu_ack,
  output logic             o_cpu_wait_n,
  input  logic             i_disp_active,
  input  logic [AW-1:0]    i_disp_addr,
  output logic [7:0]       o_disp_data,
  output logic             o_disp_valid,
  output logic [AW-1:0]    o_ram_addr,
  output logic             o_ram_we,
  output logic [7:0]       o_ram_wdata,
  input  logic [7:0]       i_ram_rdata,
  output logic [CNT_W-1:0] o_coll_cnt
);

  logic [SLOT_W-1:0] w_slot_cnt;
  logic              w_slot0;
  logic              w_slot1;
  logic              w_grant;
  logic              w_collide;
  logic              w_cpu_start;
  logic              w_fetch;
  state_t            r_state;
  state_t            w_state_nxt;

  logic [AW-1:0]     r_ram_addr;
  logic              r_ram_we;
  logic [7:0]        r_ram_wdata;
  logic [7:0]        r_cpu_rdata;
  logic              r_cpu_ack;
  logic [7:0]        r_disp_data;
  logic              r_disp_valid;
  logic              r_fetch_pend;
  logic [CNT_W-1:0]  r_coll_cnt;

  nascom_vram_arbiter_slot_ctr #(
    .CHAR_CLKS (CHAR_CLKS)
  ) u_slot_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .o_slot_cnt (w_slot_cnt),
    .o_slot0    (w_slot0)
  );

  assign w_slot1 = (w_slot_cnt == SLOT_W'(1));

  // A collision is a fresh CPU request landing on an active display slot.
  assign w_collide = (r_state == ST_IDLE) & i_cpu_req & w_slot0 & i_disp_active;

`ifdef NASCOM_VRAM_WAIT_EN
  assign w_grant      = ~w_slot0 | ~i_disp_active;
  assign o_cpu_wait_n = ~w_collide;
`else
  assign w_grant      = 1'b1;
  assign o_cpu_wait_n = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; the CPU address phase only ever starts from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cpu_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cpu_req && w_grant) begin
          w_cpu_start = 1'b1;
          w_state_nxt = i_cpu_wr ? ST_CPU_WR : ST_CPU_RD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CPU_RD: w_state_nxt = ST_HOLD;
      ST_CPU_WR: w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (!i_cpu_req) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Display takes the address phase in slot 0 unless the CPU claimed it.
  assign w_fetch = w_slot0 & i_disp_active & ~w_cpu_start;

  // RAM port address phase: CPU access or display fetch, write strobe lasts one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_addr  <= {AW{1'b0}};
      r_ram_we    <= 1'b0;
      r_ram_wdata <= 8'h00;
    end else if (w_cpu_start) begin
      r_ram_addr  <= i_cpu_addr;
      r_ram_we    <= i_cpu_wr;
      r_ram_wdata <= i_cpu_wdata;
    end else if (w_fetch) begin
      r_ram_addr  <= i_disp_addr;
      r_ram_we    <= 1'b0;
    end else begin
      r_ram_we    <= 1'b0;
    end
  end

  // CPU data phase: capture read data and pulse the acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_rdata <= 8'h00;
      r_cpu_ack   <= 1'b0;
    end else begin
      r_cpu_ack <= (r_state == ST_CPU_RD) | (r_state == ST_CPU_WR);
      if (r_state == ST_CPU_RD) begin
        r_cpu_rdata <= i_ram_rdata;
      end else begin
        r_cpu_rdata <= r_cpu_rdata;
      end
    end
  end

  // Display data phase in slot 1. If the CPU stole slot 0 the byte on the
  // bus is the CPU's (write data or read data), which gives the "snow".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pend <= 1'b0;
      r_disp_data  <= 8'h00;
      r_disp_valid <= 1'b0;
    end else begin
      r_fetch_pend <= w_slot0 & i_disp_active;
      if (w_slot1 && r_fetch_pend) begin
        r_disp_data  <= r_ram_we ? r_ram_wdata : i_ram_rdata;
        r_disp_valid <= 1'b1;
      end else begin
        r_disp_valid <= 1'b0;
      end
    end
  end

  // Saturating collision counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coll_cnt <= {CNT_W{1'b0}};
    end else if (w_collide && (r_coll_cnt != {CNT_W{1'b1}})) begin
      r_coll_cnt <= r_coll_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_coll_cnt <= r_coll_cnt;
    end
  end

  assign o_ram_addr   = r_ram_addr;
  assign o_ram_we     = r_ram_we;
  assign o_ram_wdata  = r_ram_wdata;
  assign o_cpu_rdata  = r_cpu_rdata;
  assign o_cpu_ack    = r_cpu_ack;
  assign o_disp_data  = r_disp_data;
  assign o_disp_valid = r_disp_valid;
  assign o_coll_cnt   = r_coll_cnt;

endmodule
